// File: rtl/key_pulse_conditioner_pkg.sv
// Shared types and board defaults for the pushbutton conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_pulse_conditioner_pkg;

   // 3-bit FSM state encoding, values fixed so they read the same in waveforms and docs
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      REPEAT       = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_t;

   // Timing defaults for the 50 MHz board clock
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms
   localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Key input / counter-enable bundle between the button pad and the counter.
// Latency: n/a (wires only).
// Backpressure: none; pulse is a fire-and-forget strobe.
interface key_pulse_conditioner_if;
   logic key_n;      // raw pushbutton, 0 = pressed, asynchronous
   logic repeat_en;  // allow auto-repeat while held
   logic pulse;      // one-cycle counter enable
   logic pressed;    // debounced key level, 1 = pressed

   modport master (output key_n, output repeat_en, input pulse, input pressed);
   modport slave  (input key_n, input repeat_en, output pulse, output pressed);
endinterface

// File: rtl/key_pulse_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Latency: 2 clk from d to q.
// Backpressure: none.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic aclr,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw level through two flops; reset parks both at the idle level
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces an active-low pushbutton into a one-cycle count enable with optional auto-repeat.
// Latency: press to pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 clk.
// Backpressure: none; pulse is a strobe the counter must accept every cycle it is high.
module key_pulse_conditioner
   import key_pulse_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    aclr,
   key_pulse_conditioner_if.slave  bus
);

   // Terminal counts, truncated to the counter width
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             ks;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             pressed_q, pressed_d;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .aclr (aclr),
      .d    (bus.key_n),
      .q    (ks)
   );

   // State, shared counter and registered outputs; reset clears outputs without a clock
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pulse_q   <= 1'b0;
         pressed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         pressed_q <= pressed_d;
      end
   end

   // Next state, counter and strobe; every branch resets or saturates cnt so it never wraps
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!ks) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (ks) begin
               state_d = IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (ks) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == DLY_LAST) begin
               // Without repeat_en the counter parks here, so a later enable fires immediately
               if (bus.repeat_en) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         REPEAT: begin
            if (ks) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (!bus.repeat_en) begin
               state_d = HELD;
               cnt_d   = DLY_LAST;
            end else if (cnt_q == PER_LAST) begin
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (!ks) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      pressed_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
   end

   assign bus.pulse   = pulse_q;
   assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with an event-age reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_pulse_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk;
   logic aclr;
   int   cyc;
   int   vectors;
   int   miscompares;

   key_pulse_conditioner_if bus ();

   key_pulse_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_W           (4)
   ) dut (
      .clk  (clk),
      .aclr (aclr),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: tracks how long the synchronized key has disagreed with the
   // accepted level, how long the key has been steadily held, and how long since the
   // last strobe. Pulses fall out of those ages rather than out of a state machine.
   bit m_s1, m_s2, m_pulse, m_pressed, m_train;
   int run, hold_age, since;
   bit k;

   always @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_pulse = 1'b0; m_pressed = 1'b0;
         m_train = 1'b0; run = 0; hold_age = 0; since = 0;
      end else begin
         k = m_s2;
         m_s2 = m_s1;
         m_s1 = bus.key_n;
         m_pulse = 1'b0;
         if (!m_pressed) begin
            if (k == 1'b0) begin
               run++;
               if (run == D + 1) begin
                  m_pulse = 1'b1; m_pressed = 1'b1; run = 0;
                  hold_age = 0; since = 0; m_train = 1'b0;
               end
            end else begin
               run = 0;
            end
         end else if (k == 1'b1) begin
            run++;
            if (run == D + 1) begin
               m_pressed = 1'b0; run = 0;
            end
         end else if (run > 0) begin
            // release bounce: hold restarts from scratch
            run = 0; hold_age = 0; m_train = 1'b0;
         end else begin
            if (hold_age < 1000) hold_age++;
            if (since < 1000) since++;
            if (m_train && !bus.repeat_en) begin
               m_train = 1'b0;
            end else if (m_train && since >= RP) begin
               m_pulse = 1'b1; since = 0;
            end else if (!m_train && bus.repeat_en && hold_age >= RD) begin
               m_pulse = 1'b1; since = 0; m_train = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus pulse/fall timestamps for literal checks
   int pq[$];
   int fall_cyc;
   bit prev_pr;

   always @(negedge clk) begin
      vectors++;
      if (bus.pulse !== m_pulse) begin
         miscompares++;
         $display("FAIL pulse@%0d: got %b expected %b", cyc, bus.pulse, m_pulse);
      end
      vectors++;
      if (bus.pressed !== m_pressed) begin
         miscompares++;
         $display("FAIL pressed@%0d: got %b expected %b", cyc, bus.pressed, m_pressed);
      end
      if (bus.pulse === 1'b1) pq.push_back(cyc);
      if (prev_pr && bus.pressed === 1'b0) fall_cyc = cyc;
      prev_pr = (bus.pressed === 1'b1);
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   function automatic int pulse_off(input int i, input int t0);
      if (i < pq.size()) return pq[i] - t0;
      return -1;
   endfunction

   int t0;
   int exp_off;

   initial begin
      cyc = 0; vectors = 0; miscompares = 0; fall_cyc = -1; prev_pr = 1'b0;
      bus.key_n = 1'b1;
      bus.repeat_en = 1'b0;
      aclr = 1'b1;
      #2 aclr = 1'b0;
      #3;
      chk("rst_pulse", int'(bus.pulse), 0);
      chk("rst_pressed", int'(bus.pressed), 0);
      tick(); tick();
      #2 aclr = 1'b1;
      tick(); tick();

      // Clean press: one pulse 2+D+1 edges after the fall, no repeat with repeat_en low
      pq.delete();
      t0 = cyc;
      bus.key_n = 1'b0;
      wait_to(t0 + 20);
      chk("press_count", pq.size(), 1);
      chk("press_latency", pulse_off(0, t0), 7);
      chk("press_level", int'(bus.pressed), 1);
      t0 = cyc;
      fall_cyc = -1;
      bus.key_n = 1'b1;
      wait_to(t0 + 10);
      // release: 2 sync + 1 edge into RELEASE_WAIT + D count edges
      chk("release1_latency", fall_cyc - t0, 7);
      chk("release1_level", int'(bus.pressed), 0);

      // Press bounce: two short lows never reach the debounce count
      pq.delete();
      bus.key_n = 1'b0; tick(); tick();
      bus.key_n = 1'b1; tick();
      bus.key_n = 1'b0; tick(); tick();
      bus.key_n = 1'b1;
      repeat (10) tick();
      chk("bounce_pulses", pq.size(), 0);
      chk("bounce_pressed", int'(bus.pressed), 0);

      // Auto-repeat: first repeat RD edges after the press pulse, then every RP
      pq.delete();
      bus.repeat_en = 1'b1;
      t0 = cyc;
      bus.key_n = 1'b0;
      wait_to(t0 + 37);
      chk("repeat_count", pq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         exp_off = (i == 0) ? 7 : 17 + RP * (i - 1);
         chk($sformatf("repeat_off%0d", i), pulse_off(i, t0), exp_off);
      end
      for (int i = 1; i < pq.size(); i++)
         chk($sformatf("repeat_gap%0d", i), int'(pq[i] - pq[i-1] > 1), 1);

      // Release bounce while held: no pulse, pressed stays high, then a clean release
      bus.repeat_en = 1'b0;
      repeat (3) tick();
      pq.delete();
      bus.key_n = 1'b1; tick(); tick();
      bus.key_n = 1'b0;
      repeat (6) tick();
      chk("relbounce_pulses", pq.size(), 0);
      chk("relbounce_pressed", int'(bus.pressed), 1);
      t0 = cyc;
      fall_cyc = -1;
      bus.key_n = 1'b1;
      wait_to(t0 + 10);
      chk("release2_latency", fall_cyc - t0, 7);
      chk("release2_pulses", pq.size(), 0);

      // Repeat gating: drop repeat_en inside the train, raise it, expect pulse next edge
      pq.delete();
      bus.repeat_en = 1'b1;
      t0 = cyc;
      bus.key_n = 1'b0;
      wait_to(t0 + 18);
      bus.repeat_en = 1'b0;
      wait_to(t0 + 23);
      bus.repeat_en = 1'b1;
      wait_to(t0 + 31);
      chk("gate_count", pq.size(), 5);
      chk("gate_off0", pulse_off(0, t0), 7);
      chk("gate_off1", pulse_off(1, t0), 17);
      chk("gate_off2", pulse_off(2, t0), 24);
      chk("gate_off3", pulse_off(3, t0), 27);
      chk("gate_off4", pulse_off(4, t0), 30);

      // Asynchronous reset in the middle of a strobe, key still held
      wait_to(t0 + 33);
      #2;
      chk("pre_rst_pulse", int'(bus.pulse), 1);
      aclr = 1'b0;
      #1;
      chk("async_rst_pulse", int'(bus.pulse), 0);
      chk("async_rst_pressed", int'(bus.pressed), 0);
      @(posedge clk);
      @(posedge clk);
      #3;
      aclr = 1'b1;
      t0 = cyc;
      pq.delete();
      wait_to(t0 + 12);
      chk("post_rst_count", pq.size(), 1);
      chk("post_rst_latency", pulse_off(0, t0), 7);

      bus.key_n = 1'b1;
      repeat (12) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
